// File: rtl/alarm_ctrl_pkg.sv
// Mode encodings shared by the button controller and the time/alarm datapath.
package alarm_ctrl_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE          = 3'd0,
    MODE_SET_TIME_HR   = 3'd1,
    MODE_SET_TIME_MIN  = 3'd2,
    MODE_SET_ALARM_HR  = 3'd3,
    MODE_SET_ALARM_MIN = 3'd4
  } mode_t;

  function automatic logic is_edit_mode(input mode_t m);
    return m != MODE_IDLE;
  endfunction

endpackage

// File: rtl/alarm_button_controller_btn_edge_repeat.sv
// Rising-edge detector for one +/- button with optional hold-to-repeat.
// AUTO_REPEAT_EN selects the repeat down-counter; without it each press gives one request.
module btn_edge_repeat #(
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic en_i,
`ifdef AUTO_REPEAT_EN
  input  logic clr_i,
`endif
  output logic pulse_req_o
);

  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("btn_edge_repeat: REPEAT_DELAY must be >= 2 and REPEAT_PERIOD >= 1");
  end

  logic btn_q;
  logic rise;

  assign rise = btn_i & ~btn_q;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic             active_q;
  logic [RPT_W-1:0] cnt_q;
  logic             fire;

  // Repeat only arms on an accepted press, so a button held into a new mode stays silent.
  assign fire        = active_q & btn_i & (cnt_q == '0);
  assign pulse_req_o = en_i & (rise | fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q    <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      btn_q <= btn_i;
      if (clr_i || !btn_i) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else if (rise && en_i) begin
        active_q <= 1'b1;
        cnt_q    <= RPT_W'(REPEAT_DELAY - 1);
      end else if (active_q) begin
        cnt_q <= (cnt_q == '0) ? RPT_W'(REPEAT_PERIOD - 1) : cnt_q - RPT_W'(1);
      end
    end
  end
`else
  assign pulse_req_o = en_i & rise;

  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn_i;
  end
`endif

endmodule

// File: rtl/alarm_button_controller.sv
// Button-driven mode sequencer for time/alarm editing; AUTO_REPEAT_EN enables +/- hold-to-repeat.
// mode | meaning: IDLE run | SET_TIME_HR/MIN edit time | SET_ALARM_HR/MIN edit alarm
module alarm_button_controller
  import alarm_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int TIMEOUT       = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              plus_db,
  input  logic              minus_db,
  input  logic              program_db,
  input  logic              set_alarm_db,
  input  logic              turn_off_db,
  input  logic              alarm_ringing,
  output logic [MODE_W-1:0] mode,
  output logic              inc_pulse,
  output logic              dec_pulse,
  output logic              commit_time,
  output logic              commit_alarm,
  output logic              abort,
  output logic              stop_alarm,
  output logic              alarm_armed
);

  if (TIMEOUT < 2) begin : g_param_check
    $error("alarm_button_controller: TIMEOUT must be >= 2");
  end

  localparam int            TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  mode_t           mode_q;
  logic            inc_q, dec_q, ct_q, ca_q, abort_q, stop_q, armed_q;
  logic            prog_q, set_q, toff_q;
  logic [TO_W-1:0] to_cnt_q;

  logic in_set, prog_rise, set_rise, toff_rise;
  logic ev_stop, ev_abort_btn, ev_toggle, ev_prog, ev_set, hi_evt;
  logic both, btn_en, plus_req, minus_req, accepted, to_hit;

  assign in_set    = is_edit_mode(mode_q);
  assign prog_rise = program_db & ~prog_q;
  assign set_rise  = set_alarm_db & ~set_q;
  assign toff_rise = turn_off_db & ~toff_q;

  assign ev_stop      = toff_rise & alarm_ringing;
  assign ev_abort_btn = toff_rise & ~alarm_ringing & in_set;
  assign ev_toggle    = toff_rise & ~alarm_ringing & ~in_set;
  assign ev_prog      = ~toff_rise & prog_rise &
                        (mode_q inside {MODE_IDLE, MODE_SET_TIME_HR, MODE_SET_TIME_MIN});
  assign ev_set       = ~toff_rise & set_rise & ~ev_prog &
                        (mode_q inside {MODE_IDLE, MODE_SET_ALARM_HR, MODE_SET_ALARM_MIN});
  // Ignored program/set_alarm edges do not block a +/- press in the same cycle.
  assign hi_evt       = toff_rise | ev_prog | ev_set;

  assign both     = plus_db & minus_db;
  assign btn_en   = in_set & ~hi_evt & ~both;
  assign accepted = hi_evt | plus_req | minus_req;
  assign to_hit   = in_set & ~accepted & (to_cnt_q == '0);

`ifdef AUTO_REPEAT_EN
  logic btn_clr;
  assign btn_clr = ev_abort_btn | ev_prog | ev_set | to_hit | both;
`endif

  btn_edge_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_plus (
    .clk        (clk),
    .rst        (rst),
    .btn_i      (plus_db),
    .en_i       (btn_en),
`ifdef AUTO_REPEAT_EN
    .clr_i      (btn_clr),
`endif
    .pulse_req_o(plus_req)
  );

  btn_edge_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_minus (
    .clk        (clk),
    .rst        (rst),
    .btn_i      (minus_db),
    .en_i       (btn_en),
`ifdef AUTO_REPEAT_EN
    .clr_i      (btn_clr),
`endif
    .pulse_req_o(minus_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_IDLE;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      ct_q     <= 1'b0;
      ca_q     <= 1'b0;
      abort_q  <= 1'b0;
      stop_q   <= 1'b0;
      armed_q  <= 1'b0;
      prog_q   <= 1'b0;
      set_q    <= 1'b0;
      toff_q   <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      prog_q  <= program_db;
      set_q   <= set_alarm_db;
      toff_q  <= turn_off_db;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      ct_q    <= 1'b0;
      ca_q    <= 1'b0;
      abort_q <= 1'b0;
      stop_q  <= 1'b0;

      if (ev_stop) begin
        stop_q <= 1'b1;
      end else if (ev_abort_btn) begin
        abort_q <= 1'b1;
        mode_q  <= MODE_IDLE;
      end else if (ev_toggle) begin
        armed_q <= ~armed_q;
      end else if (ev_prog) begin
        case (mode_q)
          MODE_IDLE:        mode_q <= MODE_SET_TIME_HR;
          MODE_SET_TIME_HR: mode_q <= MODE_SET_TIME_MIN;
          MODE_SET_TIME_MIN: begin
            mode_q <= MODE_IDLE;
            ct_q   <= 1'b1;
          end
          default:          mode_q <= mode_q;
        endcase
      end else if (ev_set) begin
        case (mode_q)
          MODE_IDLE:         mode_q <= MODE_SET_ALARM_HR;
          MODE_SET_ALARM_HR: mode_q <= MODE_SET_ALARM_MIN;
          MODE_SET_ALARM_MIN: begin
            mode_q  <= MODE_IDLE;
            ca_q    <= 1'b1;
            armed_q <= 1'b1;
          end
          default:           mode_q <= mode_q;
        endcase
      end else if (plus_req) begin
        inc_q <= 1'b1;
      end else if (minus_req) begin
        dec_q <= 1'b1;
      end else if (to_hit) begin
        abort_q <= 1'b1;
        mode_q  <= MODE_IDLE;
      end

      // Idle timer: reloaded by any accepted event, runs down only while editing.
      if (accepted)
        to_cnt_q <= TO_LOAD;
      else if (in_set && to_cnt_q != '0)
        to_cnt_q <= to_cnt_q - TO_W'(1);
    end
  end

  assign mode         = mode_q;
  assign inc_pulse    = inc_q;
  assign dec_pulse    = dec_q;
  assign commit_time  = ct_q;
  assign commit_alarm = ca_q;
  assign abort        = abort_q;
  assign stop_alarm   = stop_q;
  assign alarm_armed  = armed_q;

endmodule

// File: tb/tb_alarm_button_controller.sv
// Directed bench for alarm_button_controller with an expected-output queue checked one cycle after each drive.
module tb_alarm_button_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       plus_db, minus_db, program_db, set_alarm_db, turn_off_db, alarm_ringing;
  logic [2:0] mode;
  logic       inc_pulse, dec_pulse, commit_time, commit_alarm, abort, stop_alarm, alarm_armed;

  always #5 clk = ~clk;

  alarm_button_controller #(
    .REPEAT_DELAY (5),
    .REPEAT_PERIOD(3),
    .TIMEOUT      (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .plus_db      (plus_db),
    .minus_db     (minus_db),
    .program_db   (program_db),
    .set_alarm_db (set_alarm_db),
    .turn_off_db  (turn_off_db),
    .alarm_ringing(alarm_ringing),
    .mode         (mode),
    .inc_pulse    (inc_pulse),
    .dec_pulse    (dec_pulse),
    .commit_time  (commit_time),
    .commit_alarm (commit_alarm),
    .abort        (abort),
    .stop_alarm   (stop_alarm),
    .alarm_armed  (alarm_armed)
  );

  // button vector order: plus, minus, program, set_alarm, turn_off
  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_PLUS = 5'b10000;
  localparam logic [4:0] B_MIN  = 5'b01000;
  localparam logic [4:0] B_PROG = 5'b00100;
  localparam logic [4:0] B_SETA = 5'b00010;
  localparam logic [4:0] B_TOFF = 5'b00001;

  // pulse vector order: inc, dec, commit_time, commit_alarm, abort, stop_alarm
  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_INC  = 6'b100000;
  localparam logic [5:0] P_DEC  = 6'b010000;
  localparam logic [5:0] P_CT   = 6'b001000;
  localparam logic [5:0] P_CA   = 6'b000100;
  localparam logic [5:0] P_AB   = 6'b000010;
  localparam logic [5:0] P_ST   = 6'b000001;

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_armed;
  bit   auto_rep;

  task automatic drive(input logic [4:0] b, input logic ring);
    {plus_db, minus_db, program_db, set_alarm_db, turn_off_db} = b;
    alarm_ringing = ring;
  endtask

  task automatic cyc(input string tag, input logic [2:0] m, input logic [5:0] p);
    exp_t       e;
    logic [9:0] got;
    e.tag = tag;
    e.v   = {m, p, exp_armed};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {mode, inc_pulse, dec_pulse, commit_time, commit_alarm, abort, stop_alarm, alarm_armed};
    e = exp_q.pop_front();
    n_assert++;
    assert (got === e.v) else begin
      n_fail++;
      $error("FAIL %s: observed mode=%0d pulses=%b armed=%b, expected mode=%0d pulses=%b armed=%b",
             e.tag, got[9:7], got[6:1], got[0], e.v[9:7], e.v[6:1], e.v[0]);
    end
  endtask

  initial begin
`ifdef AUTO_REPEAT_EN
    auto_rep = 1'b1;
`else
    auto_rep = 1'b0;
`endif
    exp_armed = 1'b0;
    rst = 1'b1;
    drive(B_NONE, 1'b0);
    cyc("reset0", 3'd0, P_NONE);
    cyc("reset1", 3'd0, P_NONE);
    rst = 1'b0;
    cyc("idle", 3'd0, P_NONE);

    // program sequence
    drive(B_PROG, 1'b0); cyc("prog1", 3'd1, P_NONE);
    drive(B_NONE, 1'b0); cyc("prog1_rel", 3'd1, P_NONE);
    drive(B_PROG, 1'b0); cyc("prog2", 3'd2, P_NONE);
    drive(B_NONE, 1'b0); cyc("prog2_rel", 3'd2, P_NONE);
    drive(B_PROG, 1'b0); cyc("prog3_commit", 3'd0, P_CT);
    drive(B_NONE, 1'b0); cyc("prog3_rel", 3'd0, P_NONE);

    // alarm sequence with one increment
    drive(B_SETA, 1'b0); cyc("seta1", 3'd3, P_NONE);
    drive(B_NONE, 1'b0); cyc("seta1_rel", 3'd3, P_NONE);
    drive(B_PLUS, 1'b0); cyc("alarm_inc", 3'd3, P_INC);
    drive(B_NONE, 1'b0); cyc("alarm_inc_rel", 3'd3, P_NONE);
    drive(B_SETA, 1'b0); cyc("seta2", 3'd4, P_NONE);
    drive(B_NONE, 1'b0); cyc("seta2_rel", 3'd4, P_NONE);
    exp_armed = 1'b1;
    drive(B_SETA, 1'b0); cyc("seta3_commit", 3'd0, P_CA);
    drive(B_NONE, 1'b0); cyc("seta3_rel", 3'd0, P_NONE);

    // plus ignored in idle; turn_off toggles armed in idle
    drive(B_PLUS, 1'b0); cyc("idle_plus", 3'd0, P_NONE);
    drive(B_NONE, 1'b0); cyc("idle_plus_rel", 3'd0, P_NONE);
    exp_armed = 1'b0;
    drive(B_TOFF, 1'b0); cyc("toggle_off", 3'd0, P_NONE);
    drive(B_NONE, 1'b0); cyc("toggle_off_rel", 3'd0, P_NONE);
    exp_armed = 1'b1;
    drive(B_TOFF, 1'b0); cyc("toggle_on", 3'd0, P_NONE);
    drive(B_NONE, 1'b0); cyc("toggle_on_rel", 3'd0, P_NONE);

    // plus held 14 cycles in SET_TIME_HR
    drive(B_PROG, 1'b0); cyc("rep_enter", 3'd1, P_NONE);
    drive(B_NONE, 1'b0); cyc("rep_enter_rel", 3'd1, P_NONE);
    for (int k = 0; k < 14; k++) begin
      logic hit;
      hit = (k == 0) || (auto_rep && (k == 5 || k == 8 || k == 11));
      drive(B_PLUS, 1'b0);
      cyc($sformatf("hold_plus_%0d", k), 3'd1, hit ? P_INC : P_NONE);
    end
    drive(B_NONE, 1'b0); cyc("hold_plus_rel", 3'd1, P_NONE);
    drive(B_MIN, 1'b0);  cyc("minus_dec", 3'd1, P_DEC);
    drive(B_NONE, 1'b0); cyc("minus_rel", 3'd1, P_NONE);

    // leave time edit, go to SET_ALARM_MIN, plus+minus together
    drive(B_PROG, 1'b0); cyc("to_min", 3'd2, P_NONE);
    drive(B_NONE, 1'b0); cyc("to_min_rel", 3'd2, P_NONE);
    drive(B_PROG, 1'b0); cyc("to_idle_commit", 3'd0, P_CT);
    drive(B_NONE, 1'b0); cyc("to_idle_rel", 3'd0, P_NONE);
    drive(B_SETA, 1'b0); cyc("am_hr", 3'd3, P_NONE);
    drive(B_NONE, 1'b0); cyc("am_hr_rel", 3'd3, P_NONE);
    drive(B_SETA, 1'b0); cyc("am_min", 3'd4, P_NONE);
    drive(B_NONE, 1'b0); cyc("am_min_rel", 3'd4, P_NONE);
    for (int k = 0; k < 7; k++) begin
      drive(B_PLUS | B_MIN, 1'b0);
      cyc($sformatf("both_%0d", k), 3'd4, P_NONE);
    end
    drive(B_NONE, 1'b0); cyc("both_rel", 3'd4, P_NONE);
    drive(B_PLUS, 1'b0); cyc("after_both_inc", 3'd4, P_INC);
    drive(B_NONE, 1'b0); cyc("after_both_rel", 3'd4, P_NONE);
    drive(B_TOFF, 1'b0); cyc("toff_abort_alarm", 3'd0, P_AB);
    drive(B_NONE, 1'b0); cyc("toff_abort_rel", 3'd0, P_NONE);

    // timeout in SET_TIME_MIN
    drive(B_PROG, 1'b0); cyc("to_hr", 3'd1, P_NONE);
    drive(B_NONE, 1'b0); cyc("to_hr_rel", 3'd1, P_NONE);
    drive(B_PROG, 1'b0); cyc("to_enter_min", 3'd2, P_NONE);
    drive(B_NONE, 1'b0);
    for (int i = 1; i < 20; i++) cyc($sformatf("to_wait_%0d", i), 3'd2, P_NONE);
    cyc("timeout_abort", 3'd0, P_AB);
    cyc("timeout_after", 3'd0, P_NONE);

    // ringing alarm: turn_off silences without leaving edit
    drive(B_PROG, 1'b0); cyc("ring_enter", 3'd1, P_NONE);
    drive(B_NONE, 1'b1); cyc("ring_enter_rel", 3'd1, P_NONE);
    drive(B_TOFF, 1'b1); cyc("ring_stop", 3'd1, P_ST);
    drive(B_NONE, 1'b1); cyc("ring_stop_rel", 3'd1, P_NONE);
    drive(B_TOFF, 1'b0); cyc("quiet_abort", 3'd0, P_AB);
    drive(B_NONE, 1'b1); cyc("quiet_abort_rel", 3'd0, P_NONE);
    drive(B_TOFF, 1'b1); cyc("ring_stop_idle", 3'd0, P_ST);
    drive(B_NONE, 1'b0); cyc("ring_stop_idle_rel", 3'd0, P_NONE);

    // priority checks
    drive(B_PROG | B_SETA, 1'b0); cyc("prog_beats_seta", 3'd1, P_NONE);
    drive(B_NONE, 1'b0);          cyc("prio_rel1", 3'd1, P_NONE);
    drive(B_SETA, 1'b0);          cyc("seta_ignored", 3'd1, P_NONE);
    drive(B_NONE, 1'b0);          cyc("prio_rel2", 3'd1, P_NONE);
    drive(B_TOFF | B_PROG | B_PLUS, 1'b0); cyc("toff_wins", 3'd0, P_AB);
    drive(B_NONE, 1'b0);          cyc("prio_rel3", 3'd0, P_NONE);

    // synchronous reset mid-edit
    drive(B_PROG, 1'b0); cyc("rst_enter", 3'd1, P_NONE);
    drive(B_NONE, 1'b0); cyc("rst_enter_rel", 3'd1, P_NONE);
    drive(B_PLUS, 1'b0);
    rst = 1'b1;
    exp_armed = 1'b0;
    cyc("rst_mid_edit", 3'd0, P_NONE);
    rst = 1'b0;
    cyc("post_rst_plus_idle", 3'd0, P_NONE);
    drive(B_NONE, 1'b0);
    cyc("post_rst_idle", 3'd0, P_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
